// File: rtl/nts_verify_seq_pkg.sv
// Shared types and constants for the nts_verify_secure sequencer.
// State encoding, sequencing error codes and the fixed nonce/tag copy length.
package nts_verify_seq_pkg;

   localparam int unsigned LEN_W = 10;
   localparam int unsigned ERR_W = 3;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CHECK,
      S_AD_ISSUE,
      S_AD_WAIT,
      S_NONCE_ISSUE,
      S_NONCE_WAIT,
      S_TAG_ISSUE,
      S_TAG_WAIT,
      S_VERIFY_ISSUE,
      S_VERIFY_WAIT,
      S_DONE
   } state_t;

   localparam logic [ERR_W-1:0] ERR_NONE       = 3'd0;
   localparam logic [ERR_W-1:0] ERR_MISALIGNED = 3'd1;
   localparam logic [ERR_W-1:0] ERR_NO_ACCEPT  = 3'd2;
   localparam logic [ERR_W-1:0] ERR_CONFLICT   = 3'd3;
   localparam logic [ERR_W-1:0] ERR_NO_VERDICT = 3'd4;
   localparam logic [ERR_W-1:0] ERR_TIMEOUT    = 3'd5;

   localparam logic [LEN_W-1:0] NONCE_TAG_BYTES = 10'd16;

   // WAIT state that follows a given ISSUE state.
   function automatic state_t wait_of(input state_t s);
      case (s)
         S_AD_ISSUE:    return S_AD_WAIT;
         S_NONCE_ISSUE: return S_NONCE_WAIT;
         S_TAG_ISSUE:   return S_TAG_WAIT;
         default:       return S_VERIFY_WAIT;
      endcase
   endfunction

   // ISSUE state that follows a completed copy WAIT state.
   function automatic state_t issue_after(input state_t s);
      case (s)
         S_AD_WAIT:    return S_NONCE_ISSUE;
         S_NONCE_WAIT: return S_TAG_ISSUE;
         default:      return S_VERIFY_ISSUE;
      endcase
   endfunction

endpackage

// File: rtl/nts_verify_seq_watchdog.sv
// Per-phase cycle watchdog for the verify sequencer.
// Only instantiated when NTS_VERIFY_SEQ_TIMEOUT_EN is defined.
module nts_verify_seq_watchdog
   import nts_verify_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 4095
) (
   input  logic i_clk,
   input  logic i_areset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count;

   // Expire registers in the cycle the count reaches TIMEOUT_CYCLES.
   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         count  <= '0;
         expire <= 1'b0;
      end else if (clear) begin
         count  <= '0;
         expire <= 1'b0;
      end else if (enable && !expire) begin
         count  <= count + CNT_W'(1);
         expire <= (count == CNT_W'(TIMEOUT_CYCLES - 1));
      end
   end

endmodule

// File: rtl/nts_verify_secure_sequencer.sv
// Drives nts_verify_secure through copy AD, copy nonce, copy tag and verify.
// Define NTS_VERIFY_SEQ_TIMEOUT_EN to enable the per-phase watchdog (error code 5).
module nts_verify_secure_sequencer
   import nts_verify_seq_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 4095
) (
   input  logic                  i_clk,
   input  logic                  i_areset,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH+2:0] i_ad_addr,
   input  logic [LEN_W-1:0]      i_ad_bytes,
   input  logic [ADDR_WIDTH+2:0] i_nonce_addr,
   input  logic [ADDR_WIDTH+2:0] i_tag_addr,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_ok,
   output logic                  o_error,
   output logic [ERR_W-1:0]      o_error_code,
   output logic                  o_op_copy_rx_ad,
   output logic                  o_op_copy_rx_nonce,
   output logic                  o_op_copy_rx_tag,
   output logic                  o_op_verify,
   output logic [ADDR_WIDTH+2:0] o_copy_rx_addr,
   output logic [LEN_W-1:0]      o_copy_rx_bytes,
   input  logic                  i_vs_busy,
   input  logic                  i_vs_verify_good,
   input  logic                  i_vs_verify_bad
);

   localparam int unsigned BA_W = ADDR_WIDTH + 3;

   state_t            state;
   logic [BA_W-1:0]   ad_addr_q;
   logic [BA_W-1:0]   nonce_addr_q;
   logic [BA_W-1:0]   tag_addr_q;
   logic [LEN_W-1:0]  ad_bytes_q;
   logic              guard;
   logic              seen_busy;
   logic              good_q;
   logic              bad_q;
   logic              wd_expire;

`ifdef NTS_VERIFY_SEQ_TIMEOUT_EN
   logic is_issue_c, is_wait_c, wd_enable_c, wd_clear_c;

   assign is_issue_c  = state inside {S_AD_ISSUE, S_NONCE_ISSUE, S_TAG_ISSUE, S_VERIFY_ISSUE};
   assign is_wait_c   = state inside {S_AD_WAIT, S_NONCE_WAIT, S_TAG_WAIT, S_VERIFY_WAIT};
   assign wd_enable_c = is_issue_c || is_wait_c;
   // Restart the count whenever a phase ends or the sequencer leaves the phases.
   assign wd_clear_c  = !wd_enable_c || (!i_vs_busy && (is_issue_c || (is_wait_c && !guard)));

   nts_verify_seq_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .i_clk    (i_clk),
      .i_areset (i_areset),
      .clear    (wd_clear_c),
      .enable   (wd_enable_c),
      .expire   (wd_expire)
   );
`else
   logic unused_timeout;

   assign wd_expire      = 1'b0;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge i_clk or posedge i_areset) begin
      if (i_areset) begin
         state              <= S_IDLE;
         ad_addr_q          <= '0;
         nonce_addr_q       <= '0;
         tag_addr_q         <= '0;
         ad_bytes_q         <= '0;
         guard              <= 1'b0;
         seen_busy          <= 1'b0;
         good_q             <= 1'b0;
         bad_q              <= 1'b0;
         o_busy             <= 1'b0;
         o_done             <= 1'b0;
         o_ok               <= 1'b0;
         o_error            <= 1'b0;
         o_error_code       <= ERR_NONE;
         o_op_copy_rx_ad    <= 1'b0;
         o_op_copy_rx_nonce <= 1'b0;
         o_op_copy_rx_tag   <= 1'b0;
         o_op_verify        <= 1'b0;
         o_copy_rx_addr     <= '0;
         o_copy_rx_bytes    <= '0;
      end else begin
         o_done             <= 1'b0;
         o_op_copy_rx_ad    <= 1'b0;
         o_op_copy_rx_nonce <= 1'b0;
         o_op_copy_rx_tag   <= 1'b0;
         o_op_verify        <= 1'b0;
         case (state)
            S_IDLE: if (i_start) begin
               ad_addr_q    <= i_ad_addr;
               ad_bytes_q   <= i_ad_bytes;
               nonce_addr_q <= i_nonce_addr;
               tag_addr_q   <= i_tag_addr;
               o_busy       <= 1'b1;
               state        <= S_CHECK;
            end
            S_CHECK: begin
               if (nonce_addr_q[2:0] != 3'd0 || tag_addr_q[2:0] != 3'd0) begin
                  state <= S_DONE; o_done <= 1'b1; o_error <= 1'b1; o_error_code <= ERR_MISALIGNED;
               end else if (ad_bytes_q == '0) begin
                  state <= S_NONCE_ISSUE;
               end else begin
                  state <= S_AD_ISSUE;
               end
            end
            // Launch the phase's op once the verifier is idle.
            S_AD_ISSUE, S_NONCE_ISSUE, S_TAG_ISSUE, S_VERIFY_ISSUE: begin
               if (wd_expire) begin
                  state <= S_DONE; o_done <= 1'b1; o_error <= 1'b1; o_error_code <= ERR_TIMEOUT;
               end else if (!i_vs_busy) begin
                  state     <= wait_of(state);
                  guard     <= 1'b1;
                  seen_busy <= 1'b0;
                  good_q    <= 1'b0;
                  bad_q     <= 1'b0;
                  case (state)
                     S_AD_ISSUE: begin
                        o_op_copy_rx_ad <= 1'b1;
                        o_copy_rx_addr  <= ad_addr_q;
                        o_copy_rx_bytes <= ad_bytes_q;
                     end
                     S_NONCE_ISSUE: begin
                        o_op_copy_rx_nonce <= 1'b1;
                        o_copy_rx_addr     <= nonce_addr_q;
                        o_copy_rx_bytes    <= NONCE_TAG_BYTES;
                     end
                     S_TAG_ISSUE: begin
                        o_op_copy_rx_tag <= 1'b1;
                        o_copy_rx_addr   <= tag_addr_q;
                        o_copy_rx_bytes  <= NONCE_TAG_BYTES;
                     end
                     default: begin
                        o_op_verify     <= 1'b1;
                        o_copy_rx_addr  <= '0;
                        o_copy_rx_bytes <= '0;
                     end
                  endcase
               end
            end
            S_AD_WAIT, S_NONCE_WAIT, S_TAG_WAIT: begin
               if (wd_expire) begin
                  state <= S_DONE; o_done <= 1'b1; o_error <= 1'b1; o_error_code <= ERR_TIMEOUT;
               end else if (guard) begin
                  guard <= 1'b0;
               end else if (i_vs_busy) begin
                  seen_busy <= 1'b1;
               end else if (!seen_busy) begin
                  state <= S_DONE; o_done <= 1'b1; o_error <= 1'b1; o_error_code <= ERR_NO_ACCEPT;
               end else begin
                  state <= issue_after(state);
               end
            end
            // Verdict pulses may arrive in any cycle, including the one busy falls.
            S_VERIFY_WAIT: begin
               good_q <= good_q | i_vs_verify_good;
               bad_q  <= bad_q | i_vs_verify_bad;
               if (i_vs_verify_good && i_vs_verify_bad) begin
                  state <= S_DONE; o_done <= 1'b1; o_error <= 1'b1; o_error_code <= ERR_CONFLICT;
               end else if (wd_expire) begin
                  state <= S_DONE; o_done <= 1'b1; o_error <= 1'b1; o_error_code <= ERR_TIMEOUT;
               end else if (guard) begin
                  guard <= 1'b0;
               end else if (i_vs_busy) begin
                  seen_busy <= 1'b1;
               end else if (!seen_busy) begin
                  state <= S_DONE; o_done <= 1'b1; o_error <= 1'b1; o_error_code <= ERR_NO_ACCEPT;
               end else if (!(good_q || bad_q || i_vs_verify_good || i_vs_verify_bad)) begin
                  state <= S_DONE; o_done <= 1'b1; o_error <= 1'b1; o_error_code <= ERR_NO_VERDICT;
               end else begin
                  state  <= S_DONE;
                  o_done <= 1'b1;
                  o_ok   <= (good_q | i_vs_verify_good) & ~(bad_q | i_vs_verify_bad);
               end
            end
            S_DONE: begin
               state        <= S_IDLE;
               o_busy       <= 1'b0;
               o_ok         <= 1'b0;
               o_error      <= 1'b0;
               o_error_code <= ERR_NONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nts_verify_secure_sequencer.sv
// Directed self-checking bench for nts_verify_secure_sequencer with a small verifier model.
// Stuck-busy expectations follow NTS_VERIFY_SEQ_TIMEOUT_EN.
module tb_nts_verify_secure_sequencer;

   localparam int unsigned AW = 8;
   localparam int unsigned BW = AW + 3;
   localparam int unsigned TO = 50;

   logic          clk = 1'b0;
   logic          areset = 1'b1;
   logic          start = 1'b0;
   logic [BW-1:0] ad_addr = '0;
   logic [9:0]    ad_bytes = '0;
   logic [BW-1:0] nonce_addr = '0;
   logic [BW-1:0] tag_addr = '0;
   logic          busy, done, ok, error;
   logic [2:0]    error_code;
   logic          op_ad, op_nonce, op_tag, op_verify;
   logic [BW-1:0] copy_addr;
   logic [9:0]    copy_bytes;
   logic          vs_busy, model_busy, vs_good, vs_bad;
   logic          stuck_busy = 1'b0;
   logic          mode_good = 1'b1;
   logic [31:0]   all_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign vs_busy = model_busy | stuck_busy;
   assign all_out = {busy, done, ok, error, error_code, op_ad, op_nonce, op_tag, op_verify,
                     copy_addr, copy_bytes};

   nts_verify_secure_sequencer #(
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .i_clk              (clk),
      .i_areset           (areset),
      .i_start            (start),
      .i_ad_addr          (ad_addr),
      .i_ad_bytes         (ad_bytes),
      .i_nonce_addr       (nonce_addr),
      .i_tag_addr         (tag_addr),
      .o_busy             (busy),
      .o_done             (done),
      .o_ok               (ok),
      .o_error            (error),
      .o_error_code       (error_code),
      .o_op_copy_rx_ad    (op_ad),
      .o_op_copy_rx_nonce (op_nonce),
      .o_op_copy_rx_tag   (op_tag),
      .o_op_verify        (op_verify),
      .o_copy_rx_addr     (copy_addr),
      .o_copy_rx_bytes    (copy_bytes),
      .i_vs_busy          (vs_busy),
      .i_vs_verify_good   (vs_good),
      .i_vs_verify_bad    (vs_bad)
   );

   // Verifier model: 20 busy cycles per op, verdict pulsed as busy falls.
   int   busy_cnt;
   logic is_verify;
   always @(posedge clk or posedge areset) begin
      if (areset) begin
         busy_cnt <= 0; model_busy <= 1'b0; is_verify <= 1'b0; vs_good <= 1'b0; vs_bad <= 1'b0;
      end else begin
         vs_good <= 1'b0;
         vs_bad  <= 1'b0;
         if (op_ad || op_nonce || op_tag || op_verify) begin
            busy_cnt <= 20; model_busy <= 1'b1; is_verify <= op_verify;
         end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
               model_busy <= 1'b0;
               if (is_verify) begin vs_good <= mode_good; vs_bad <= !mode_good; end
            end
         end
      end
   end

   // Op monitor: logs every pulse and counts overlapping pulses.
   logic [3:0]    op_kind [64];
   logic [9:0]    op_bytes [64];
   logic [BW-1:0] op_addr [64];
   int n_ops = 0;
   int overlaps = 0;
   always @(negedge clk) begin
      if ({op_ad, op_nonce, op_tag, op_verify} != 4'b0) begin
         if ($countones({op_ad, op_nonce, op_tag, op_verify}) > 1) overlaps <= overlaps + 1;
         if (n_ops < 64) begin
            op_kind[n_ops]  <= {op_ad, op_nonce, op_tag, op_verify};
            op_bytes[n_ops] <= copy_bytes;
            op_addr[n_ops]  <= copy_addr;
         end
         n_ops <= n_ops + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns in cycle 1 relative to the start pulse.
   task automatic do_start(input logic [BW-1:0] ad, input logic [9:0] nb,
                           input logic [BW-1:0] na, input logic [BW-1:0] ta);
      start = 1'b1; ad_addr = ad; ad_bytes = nb; nonce_addr = na; tag_addr = ta;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int max, output int n);
      n = 0;
      while (done !== 1'b1 && n < max) begin
         tick();
         n++;
      end
   endtask

   int base, base2, n;

   initial begin
      // Reset state
      repeat (3) tick();
      check("reset_outputs", all_out, 32'h0);
      areset = 1'b0;
      tick();

      // Happy path with exact first-op timing
      base = n_ops;
      do_start(11'h080, 10'd188, 11'h180, 11'h198);
      check("busy_cycle1", 32'(busy), 32'd1);
      tick();
      check("no_op_cycle2", 32'(op_ad), 32'd0);
      tick();
      check("op_ad_cycle3", 32'(op_ad), 32'd1);
      check("ad_bytes_cycle3", 32'(copy_bytes), 32'd188);
      check("ad_addr_cycle3", 32'(copy_addr), 32'h080);
      wait_done(200, n);
      check("happy_done", 32'(done), 32'd1);
      check("happy_ok", 32'(ok), 32'd1);
      check("happy_error", 32'(error), 32'd0);
      check("happy_nops", 32'(n_ops - base), 32'd4);
      check("happy_kind0", 32'(op_kind[base]), 32'h8);
      check("happy_kind1", 32'(op_kind[base+1]), 32'h4);
      check("happy_kind2", 32'(op_kind[base+2]), 32'h2);
      check("happy_kind3", 32'(op_kind[base+3]), 32'h1);
      check("happy_bytes1", 32'(op_bytes[base+1]), 32'd16);
      check("happy_bytes2", 32'(op_bytes[base+2]), 32'd16);
      check("happy_bytes3", 32'(op_bytes[base+3]), 32'd0);
      check("happy_nonce_addr", 32'(op_addr[base+1]), 32'h180);
      check("happy_tag_addr", 32'(op_addr[base+2]), 32'h198);
      tick();
      check("happy_done_fall", 32'(done), 32'd0);
      check("happy_busy_fall", 32'(busy), 32'd0);

      // Bad tag
      mode_good = 1'b0;
      base = n_ops;
      do_start(11'h080, 10'd188, 11'h180, 11'h198);
      wait_done(200, n);
      check("bad_done", 32'(done), 32'd1);
      check("bad_ok", 32'(ok), 32'd0);
      check("bad_error", 32'(error), 32'd0);
      check("bad_nops", 32'(n_ops - base), 32'd4);
      mode_good = 1'b1;
      tick();

      // AD skipped
      base = n_ops;
      do_start(11'h080, 10'd0, 11'h180, 11'h198);
      wait_done(200, n);
      check("skip_ok", 32'(ok), 32'd1);
      check("skip_nops", 32'(n_ops - base), 32'd3);
      check("skip_first_kind", 32'(op_kind[base]), 32'h4);
      tick();

      // Misaligned tag
      base = n_ops;
      do_start(11'h080, 10'd188, 11'h180, 11'h19C);
      tick();
      check("misalign_done_cycle2", 32'(done), 32'd1);
      check("misalign_error", 32'(error), 32'd1);
      check("misalign_code", 32'(error_code), 32'd1);
      tick();
      check("misalign_busy_fall", 32'(busy), 32'd0);
      check("misalign_nops", 32'(n_ops - base), 32'd0);

      // Verifier stuck busy
      stuck_busy = 1'b1;
      base = n_ops;
      do_start(11'h080, 10'd188, 11'h180, 11'h198);
`ifdef NTS_VERIFY_SEQ_TIMEOUT_EN
      wait_done(100, n);
      check("stuck_done", 32'(done), 32'd1);
      check("stuck_code", 32'(error_code), 32'd5);
      check("stuck_not_early", 32'(n >= 50), 32'd1);
      check("stuck_not_late", 32'(n <= 55), 32'd1);
      stuck_busy = 1'b0;
      tick();
`else
      repeat (999) tick();
      check("stuck_busy_c1000", 32'(busy), 32'd1);
      check("stuck_no_done", 32'(done), 32'd0);
      areset = 1'b1;
      #1;
      check("stuck_reset_outputs", all_out, 32'h0);
      tick();
      areset = 1'b0;
      stuck_busy = 1'b0;
      tick();
`endif
      check("stuck_nops", 32'(n_ops - base), 32'd0);

      // Reset during NONCE_WAIT
      do_start(11'h080, 10'd188, 11'h180, 11'h198);
      n = 0;
      while (op_nonce !== 1'b1 && n < 100) begin tick(); n++; end
      check("rst_reached_nonce", 32'(op_nonce), 32'd1);
      repeat (3) tick();
      areset = 1'b1;
      #1;
      check("rst_outputs_async", all_out, 32'h0);
      base2 = n_ops;
      tick();
      tick();
      areset = 1'b0;
      tick();
      tick();
      check("rst_outputs_after", all_out, 32'h0);
      check("rst_no_ops", 32'(n_ops - base2), 32'd0);

      // Fresh sequence with a second start while busy
      base = n_ops;
      do_start(11'h080, 10'd188, 11'h180, 11'h198);
      repeat (4) tick();
      do_start(11'h000, 10'd0, 11'h181, 11'h19C);
      check("ignored_start_busy", 32'(busy), 32'd1);
      check("ignored_start_no_done", 32'(done), 32'd0);
      wait_done(200, n);
      check("fresh_ok", 32'(ok), 32'd1);
      check("fresh_error", 32'(error), 32'd0);
      check("fresh_nops", 32'(n_ops - base), 32'd4);
      check("fresh_ad_bytes", 32'(op_bytes[base]), 32'd188);
      check("fresh_ad_addr", 32'(op_addr[base]), 32'h080);
      repeat (5) tick();
      check("fresh_idle", 32'(busy), 32'd0);
      check("fresh_no_extra_ops", 32'(n_ops - base), 32'd4);
      check("no_overlaps", 32'(overlaps), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
